// File: rtl/regfile_sequencer.sv
// Control sequencer for the 8x16 register file, A/B/C operand registers and ALU.
// Accepts one instruction per valid/ready handshake and steps it through Moore-decoded strobe states.
module regfile_sequencer #(
  parameter int DATA_W = 16,
  parameter int REG_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [15:0]       instr,
  output logic              in_ready,
  output logic [REG_W-1:0]  readnum,
  output logic [REG_W-1:0]  writenum,
  output logic              write,
  output logic              loada,
  output logic              loadb,
  output logic              loadc,
  output logic              loads,
  output logic              asel,
  output logic              vsel,
  output logic [1:0]        shift,
  output logic [1:0]        aluop,
  output logic [DATA_W-1:0] sximm8,
  output logic              done,
  output logic              err
);

  // state | meaning
  // IDLE  | ready for a new instruction
  // WIMM  | write sign-extended imm8 into Rn
  // GETA  | read Rn into A
  // GETB  | read Rm into B
  // EXEC  | ALU result into C (and flags for CMP)
  // WREG  | write C into Rd
  // DONE  | retire pulse
  // ERR   | illegal instruction pulse
  typedef enum logic [2:0] {
    S_IDLE, S_WIMM, S_GETA, S_GETB, S_EXEC, S_WREG, S_DONE, S_ERR
  } state_t;

  localparam logic [2:0] OPC_MOV = 3'b110;
  localparam logic [2:0] OPC_ALU = 3'b101;

  state_t      state, state_nxt;
  logic [15:0] instr_q;

  logic [2:0] in_opc, q_opc;
  logic [1:0] in_op, q_op;
  logic       accept;

  assign in_opc = instr[15:13];
  assign in_op  = instr[12:11];
  assign q_opc  = instr_q[15:13];
  assign q_op   = instr_q[12:11];
  assign accept = (state == S_IDLE) && in_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      instr_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) instr_q <= instr;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    write     = 1'b0;
    loada     = 1'b0;
    loadb     = 1'b0;
    loadc     = 1'b0;
    loads     = 1'b0;
    asel      = 1'b0;
    vsel      = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    readnum   = REG_W'(instr_q[2:0]);
    writenum  = REG_W'(instr_q[7:5]);
    shift     = instr_q[4:3];
    aluop     = instr_q[12:11];
    sximm8    = {{(DATA_W-8){instr_q[7]}}, instr_q[7:0]};

    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (in_opc == OPC_MOV && in_op == 2'b10)      state_nxt = S_WIMM;
          else if (in_opc == OPC_MOV && in_op == 2'b00) state_nxt = S_GETB;
          else if (in_opc == OPC_ALU && in_op == 2'b11) state_nxt = S_GETB;
          else if (in_opc == OPC_ALU)                   state_nxt = S_GETA;
          else                                          state_nxt = S_ERR;
        end
      end
      S_WIMM: begin
        writenum  = REG_W'(instr_q[10:8]);
        vsel      = 1'b1;
        write     = 1'b1;
        state_nxt = S_DONE;
      end
      S_GETA: begin
        readnum   = REG_W'(instr_q[10:8]);
        loada     = 1'b1;
        state_nxt = S_GETB;
      end
      S_GETB: begin
        loadb     = 1'b1;
        state_nxt = S_EXEC;
      end
      S_EXEC: begin
        // Only legal instructions reach here: MOV reg (opcode 110) and MVN bypass A.
        loadc     = 1'b1;
        asel      = (q_opc == OPC_MOV) || (q_op == 2'b11);
        loads     = (q_opc == OPC_ALU) && (q_op == 2'b01);
        state_nxt = loads ? S_DONE : S_WREG;
      end
      S_WREG: begin
        write     = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        err       = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    if (reset) begin
      in_ready = 1'b0;
      write    = 1'b0;
      loada    = 1'b0;
      loadb    = 1'b0;
      loadc    = 1'b0;
      loads    = 1'b0;
      asel     = 1'b0;
      vsel     = 1'b0;
      done     = 1'b0;
      err      = 1'b0;
      readnum  = '0;
      writenum = '0;
      shift    = '0;
      aluop    = '0;
      sximm8   = '0;
    end
  end

endmodule

// File: tb/tb_regfile_sequencer.sv
// Self-checking bench for regfile_sequencer: per-instruction expected strobe traces are
// queued at accept and popped/compared cycle by cycle, plus reset and throughput sequences.
module tb_regfile_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [15:0] instr;
  logic        in_ready;
  logic [2:0]  readnum;
  logic [2:0]  writenum;
  logic        write, loada, loadb, loadc, loads, asel, vsel, done, err;
  logic [1:0]  shift, aluop;
  logic [15:0] sximm8;

  regfile_sequencer #(.DATA_W(16), .REG_W(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .instr(instr),
    .in_ready(in_ready), .readnum(readnum), .writenum(writenum),
    .write(write), .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .vsel(vsel), .shift(shift), .aluop(aluop), .sximm8(sximm8),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;

  // obs bit map: 15 in_ready | 14:12 readnum | 11:9 writenum | 8 write | 7 loada | 6 loadb
  //              5 loadc | 4 loads | 3 asel | 2 vsel | 1 done | 0 err
  logic [15:0] obs;
  assign obs = {in_ready, readnum, writenum, write, loada, loadb, loadc, loads,
                asel, vsel, done, err};

  localparam logic [15:0] BASE_M = 16'h81F3;
  localparam logic [15:0] RN_M   = 16'h7000;
  localparam logic [15:0] WN_M   = 16'h0E00;
  localparam logic [15:0] AS_M   = 16'h0008;
  localparam logic [15:0] VS_M   = 16'h0004;

  typedef struct {
    string       nm;
    logic [15:0] v;
    logic [15:0] m;
  } cyc_t;

  typedef struct {
    string       nm;
    logic [15:0] ins;
    int          lat;
  } vec_t;

  cyc_t q[$];
  int   cmp_cnt = 0;
  int   mis_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      mis_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void push(input string nm, input logic [15:0] v, input logic [15:0] m);
    cyc_t c;
    c.nm = nm;
    c.v  = v;
    c.m  = m;
    q.push_back(c);
  endfunction

  // Expected per-cycle behaviour after accept, straight from the state/action table.
  function automatic void model(input logic [15:0] ins);
    logic [2:0]  opc, rn, rd, rm;
    logic [1:0]  op;
    logic [15:0] v;
    opc = ins[15:13];
    op  = ins[12:11];
    rn  = ins[10:8];
    rd  = ins[7:5];
    rm  = ins[2:0];
    if (opc == 3'b110 && op == 2'b10) begin
      v = 16'h0; v[8] = 1'b1; v[2] = 1'b1; v[11:9] = rn;
      push("wimm", v, BASE_M | WN_M | VS_M);
      v = 16'h0; v[1] = 1'b1;
      push("done", v, BASE_M);
    end else if ((opc == 3'b110 && op == 2'b00) || opc == 3'b101) begin
      if (opc == 3'b101 && op != 2'b11) begin
        v = 16'h0; v[7] = 1'b1; v[14:12] = rn;
        push("geta", v, BASE_M | RN_M);
      end
      v = 16'h0; v[6] = 1'b1; v[14:12] = rm;
      push("getb", v, BASE_M | RN_M);
      v = 16'h0; v[5] = 1'b1;
      v[3] = (opc == 3'b110) || (op == 2'b11);
      v[4] = (opc == 3'b101) && (op == 2'b01);
      push("exec", v, BASE_M | AS_M);
      if (!(opc == 3'b101 && op == 2'b01)) begin
        v = 16'h0; v[8] = 1'b1; v[11:9] = rd;
        push("wreg", v, BASE_M | WN_M | VS_M);
      end
      v = 16'h0; v[1] = 1'b1;
      push("done", v, BASE_M);
    end else begin
      v = 16'h0; v[0] = 1'b1;
      push("err", v, BASE_M);
    end
  endfunction

  task automatic run_instr(input vec_t t);
    cyc_t        c;
    int          k, lat;
    logic [15:0] ins;
    ins = t.ins;
    @(negedge clk);
    chk({t.nm, "_ready"}, in_ready, 1);
    in_valid = 1'b1;
    instr    = ins;
    model(ins);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    instr    = 16'($urandom);
    k   = 0;
    lat = 0;
    while (q.size() > 0) begin
      @(negedge clk);
      c = q.pop_front();
      k++;
      chk({t.nm, "_", c.nm}, obs & c.m, c.v & c.m);
      chk({t.nm, "_", c.nm, "_held"}, {sximm8, shift, aluop},
          {{{8{ins[7]}}, ins[7:0]}, ins[4:3], ins[12:11]});
      if ((done || err) && lat == 0) lat = k;
    end
    chk({t.nm, "_latency"}, lat, t.lat);
  endtask

  vec_t tbl[10];
  int   dn_cnt, wr_seen;

  initial begin
    tbl[0] = '{"movi_r3_m5",  16'hD3FB, 2};
    tbl[1] = '{"add_r2_r1r0", 16'hA140, 5};
    tbl[2] = '{"cmp_r5_r6",   16'hAD06, 4};
    tbl[3] = '{"ill_111",     16'hE000, 1};
    tbl[4] = '{"movr_r4_r7",  16'hC08F, 4};
    tbl[5] = '{"mvn_r5_r2",   16'hB8B2, 4};
    tbl[6] = '{"and_r6_r6r6", 16'hB6C6, 5};
    tbl[7] = '{"movi_r0_7f",  16'hD07F, 2};
    tbl[8] = '{"ill_110_01",  16'hC9AB, 1};
    tbl[9] = '{"ill_110_11",  16'hD812, 1};

    reset    = 1'b1;
    in_valid = 1'b0;
    instr    = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs_zero", {obs, sximm8, shift, aluop}, 64'h0);
    reset = 1'b0;
    #1;
    chk("post_reset_idle", {obs, sximm8, shift, aluop}, {16'h8000, 16'h0, 2'b00, 2'b00});

    for (int i = 0; i < 10; i++) run_instr(tbl[i]);

    // Reset asserted for two cycles while an ADD sits in GETB.
    @(negedge clk);
    in_valid = 1'b1;
    instr    = 16'hA140;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midadd_in_getb", obs & BASE_M, 16'h0040);
    reset = 1'b1;
    #1;
    chk("midadd_rst_c0", {obs, sximm8, shift, aluop}, 64'h0);
    @(negedge clk);
    chk("midadd_rst_c1", {obs, sximm8, shift, aluop}, 64'h0);
    @(negedge clk);
    chk("midadd_rst_c2", {obs, sximm8, shift, aluop}, 64'h0);
    reset = 1'b0;
    #1;
    chk("midadd_idle", {obs & BASE_M, sximm8}, {16'h8000, 16'h0});
    wr_seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (write || done || !in_ready) wr_seen++;
    end
    chk("midadd_no_write", wr_seen, 0);

    // in_valid held high across three MOV imm instructions.
    @(negedge clk);
    in_valid = 1'b1;
    instr    = 16'hD3FB;
    dn_cnt   = 0;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("b2b_c%0d", i), {in_ready, done}, {(i % 3 == 0), (i % 3 == 2)});
      if (done) dn_cnt++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    chk("b2b_done_count", dn_cnt, 3);
    @(negedge clk);
    chk("b2b_final_idle", obs & BASE_M, 16'h8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
